// File: rtl/tx_pkg.sv
// Shared types for the Zigbee TX sequencer: FSM states and error codes.
package tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FILL,
      GUARD,
      SEND,
      DRAIN,
      ERR
   } tx_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_UNDERRUN = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_ABORT    = 2'd3
   } err_code_t;

endpackage

// File: rtl/tx_seq_ctrl_edge_det.sv
// Registered edge detector: one flop of history, rise/fall derived from it.
module edge_det (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic din_q;

   // Keep one cycle of history of the input strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) din_q <= 1'b0;
      else          din_q <= din;
   end

   assign rise = din & ~din_q;
   assign fall = ~din & din_q;

endmodule

// File: rtl/tx_seq_ctrl.sv
// Transmit sequencer: gates the FIFO TX read enable so exactly one PSDU of
// frame_len bytes is serialised, with PA guard, fill timeout and abort.
module tx_seq_ctrl
   import tx_pkg::*;
#(
   parameter int LEN_W        = 7,
   parameter int GUARD_CYC    = 200,
   parameter int FILL_TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             fifo_mem_state,
   input  logic             iq_rate,
   output logic             en_iq,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [LEN_W+2:0] bits_sent
);

   localparam int CNT_W = LEN_W + 3;
   localparam int TMR_W = $clog2(FILL_TIMEOUT);
   localparam int GRD_W = $clog2(GUARD_CYC + 1);

   tx_state_t        state;
   err_code_t        code_q;
   logic [CNT_W-1:0] total_bits;
   logic [CNT_W-1:0] bits_q;
   logic [CNT_W-1:0] bits_inc;
   logic [TMR_W-1:0] fill_tmr;
   logic [GRD_W-1:0] guard_cnt;
   logic             iq_rise;
   logic             iq_fall;

   edge_det u_iq_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (iq_rate),
      .rise    (iq_rise),
      .fall    (iq_fall)
   );

   // Bit count after this cycle's strobe, saturating at the frame length.
   always_comb begin
      bits_inc = bits_q;
      if (iq_rise && (bits_q < total_bits)) bits_inc = bits_q + CNT_W'(1);
   end

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         code_q     <= ERR_NONE;
         total_bits <= '0;
         bits_q     <= '0;
         fill_tmr   <= '0;
         guard_cnt  <= '0;
         en_iq      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  code_q     <= ERR_NONE;
                  bits_q     <= '0;
                  total_bits <= {frame_len, 3'b000};
                  if (frame_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state    <= WAIT_FILL;
                     busy     <= 1'b1;
                     fill_tmr <= '0;
                  end
               end
            end
            WAIT_FILL: begin
               if (abort) begin
                  state  <= ERR;
                  err    <= 1'b1;
                  code_q <= ERR_ABORT;
               end else if (fifo_mem_state) begin
                  state     <= GUARD;
                  guard_cnt <= '0;
               end else if (fill_tmr == TMR_W'(FILL_TIMEOUT - 1)) begin
                  state  <= ERR;
                  err    <= 1'b1;
                  code_q <= ERR_TIMEOUT;
               end else begin
                  fill_tmr <= fill_tmr + TMR_W'(1);
               end
            end
            GUARD: begin
               if (abort) begin
                  state  <= ERR;
                  err    <= 1'b1;
                  code_q <= ERR_ABORT;
               end else if (guard_cnt == GRD_W'(GUARD_CYC - 1)) begin
                  state <= SEND;
                  en_iq <= 1'b1;
               end else begin
                  guard_cnt <= guard_cnt + GRD_W'(1);
               end
            end
            SEND: begin
               if (abort) begin
                  state  <= ERR;
                  err    <= 1'b1;
                  code_q <= ERR_ABORT;
                  en_iq  <= 1'b0;
               end else begin
                  bits_q <= bits_inc;
                  if (iq_rise && (bits_inc == total_bits)) begin
                     state <= DRAIN;
                  end else if (!fifo_mem_state && (bits_inc < total_bits)) begin
                     state  <= ERR;
                     err    <= 1'b1;
                     code_q <= ERR_UNDERRUN;
                     en_iq  <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  state  <= ERR;
                  err    <= 1'b1;
                  code_q <= ERR_ABORT;
                  en_iq  <= 1'b0;
               end else if (iq_fall) begin
                  state <= IDLE;
                  en_iq <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ERR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               en_iq <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign err_code  = code_q;
   assign bits_sent = bits_q;

endmodule

// File: doc/tx_seq_ctrl.md
Name: tx_seq_ctrl

Overview:
- Transmit sequencer for the Zigbee TX path. It gates the FIFO TX read enable (en_iq) so that exactly one PSDU of a programmed byte length is serialised.
- It waits for FIFO data and applies a PA ramp-up guard before the first chip.
- It counts bit strobes from the FIFO, stops cleanly at the frame end, and flags underrun, timeout and abort to the APB/IRQ logic.

Parameters:
- LEN_W, 7, width of frame length in bytes (PSDU max 127).
- GUARD_CYC, 200, clk cycles between data-ready and en_iq assertion (PA ramp).
- FILL_TIMEOUT, 50000, max clk cycles in WAIT_FILL before timeout error.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: launch a frame; ignored unless in IDLE.
- abort  in  1  single-cycle pulse: terminate the current frame.
- frame_len  in  LEN_W  PSDU length in bytes; sampled on an accepted start.
- fifo_mem_state  in  1  FIFO occupancy: 0 = empty, 1 = non-empty.
- iq_rate  in  1  FIFO bit strobe: high for part of each 2 MHz bit period while reading.
- en_iq  out  1  read enable to the FIFO TX.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal frame completion.
- err  out  1  one-cycle pulse on underrun, timeout or abort.
- err_code  out  2  valid with err; held until the next start. 0 = none, 1 = underrun, 2 = timeout, 3 = abort.
- bits_sent  out  LEN_W+3  bits transmitted in the current or last frame.

Behaviour:
- Reset values:
  - state = IDLE.
  - en_iq, busy, done, err = 0.
  - err_code = 0, bits_sent = 0.
- Registered output rules:
  - All outputs are registered.
  - en_iq is high only in SEND and DRAIN.
- iq_rate edge detection:
  - iq_rate is registered once (iq_q).
  - rise = iq_rate & ~iq_q; fall = ~iq_rate & iq_q.
- Frame setup:
  - total_bits = frame_len × 8 (LEN_W+3 bits wide), latched on an accepted start.
  - frame_len == 0 on start: go directly to IDLE with a done pulse; en_iq never asserts.
- States and transitions:
  - IDLE: on start, latch len, clear bits_sent, clear err_code → WAIT_FILL.
  - WAIT_FILL:
    - fifo_mem_state == 1 → GUARD and clear the timer.
    - Timer reaches FILL_TIMEOUT−1 → ERR with code 2.
  - GUARD: count GUARD_CYC cycles → SEND. en_iq rises on the first SEND cycle.
  - SEND:
    - Each rise increments bits_sent.
    - When bits_sent reaches total_bits (the cycle of the last rise) → DRAIN.
    - fifo_mem_state == 0 while bits_sent < total_bits → ERR with code 1. This check is sampled every cycle.
    - A rise and the empty condition in the same cycle: the count is taken first, then the completion check is applied.
  - DRAIN: hold en_iq = 1 until fall (last bit fully shifted) → IDLE with a done pulse and en_iq = 0.
  - ERR: one cycle; en_iq = 0, err pulse → IDLE.
- abort:
  - In WAIT_FILL, GUARD, SEND or DRAIN: → ERR with code 3 on the next cycle. abort has priority over all other transitions.
  - In IDLE: abort is ignored.
- start is ignored while busy; it is not queued.
- Counter widths:
  - The bits_sent counter saturates at total_bits and never wraps.
  - The timer is $clog2(FILL_TIMEOUT) bits wide.
- Reset asserted mid-frame: everything returns to reset values immediately; en_iq drops asynchronously.

Decomposition:
- Package tx_pkg:
  - typedef enum tx_state_t {IDLE, WAIT_FILL, GUARD, SEND, DRAIN, ERR}.
  - typedef err_code_t with constants ERR_NONE, ERR_UNDERRUN, ERR_TIMEOUT, ERR_ABORT.
- Sub-module edge_det (registered rise/fall detector), instantiated for iq_rate.
- The controller instantiates alongside FIFO_Tx at the TX top level.

Test Plan:
- Normal frame:
  - Stimulus: preload 3 bytes, frame_len = 3, start.
  - Response: en_iq rises GUARD_CYC+2 cycles after start; exactly 24 rises; done after the 24th fall; bits_sent = 24; err never asserts.
- Fill wait:
  - Stimulus: start with the FIFO empty, then write a byte after 1000 cycles.
  - Response: stays in WAIT_FILL; GUARD starts the cycle after fifo_mem_state = 1; no timeout.
- Timeout:
  - Stimulus: start with the FIFO empty, FILL_TIMEOUT = 100.
  - Response: err pulse with err_code = 2 at cycle 101; en_iq never high; busy drops.
- Underrun:
  - Stimulus: frame_len = 4, only 2 bytes loaded.
  - Response: after 16 bits fifo_mem_state = 0; err with code 1; bits_sent = 16; en_iq = 0 the next cycle.
- Abort and ignored start:
  - Stimulus: abort in the middle of SEND at bit 5; a second start pulse during busy.
  - Response: err code 3, bits_sent = 5; the second start has no effect.
- Zero length and reset:
  - Stimulus: frame_len = 0 → done with no en_iq. Then assert reset_n low during DRAIN.
  - Response: all outputs return to 0 asynchronously.
